kmac_msg_absorb: RTL and testbench
==================================

// Module: kmac_msg_absorb
// PURPOSE
// - Consumer end of the KMAC MSG interface (valid/data/strb/ready plus process/clear).
// - Writes message words lane by lane into the Keccak state and runs a permutation after each full rate block.
// - On process_i it appends SHA3/cSHAKE padding, runs the final block, then signals absorbed_o.
// PARAMETERS
// - MsgWidth    64      lane/message word width; only 64 is supported.
// - BlockWords  17      rate in lanes (17 = SHA3-256, 21 = SHAKE128); must be 1..25.
// - PadByte     8'h06   domain/pad byte inserted after the last message byte (8'h04 for cSHAKE).
// - AddrW       5       lane address width, $clog2(25).
// PORTS
// - clk_i         in   1           clock
// - rst_ni        in   1           reset, asynchronous, active-low
// - msg_valid_i   in   1           message word valid
// - msg_data_i    in   MsgWidth    message word, little-endian bytes
// - msg_strb_i    in   MsgWidth/8  byte strobe; contiguous from bit 0
// - msg_ready_o   out  1           message word accepted when valid&ready
// - process_i     in   1           pulse: message complete, start padding
// - clear_i       in   1           pulse: return to idle, drop all context
// - state_valid_o out  1           lane write strobe into the Keccak state (XOR-in)
// - state_addr_o  out  AddrW       lane index 0..BlockWords-1
// - state_data_o  out  MsgWidth    lane data
// - run_o         out  1           one-cycle pulse: start a permutation
// - run_done_i    in   1           permutation finished
// - absorbed_o    out  1           one-cycle pulse: final block permuted
// - err_o         out  1           one-cycle pulse: illegal strobe pattern, word dropped
// BEHAVIOUR
// - Reset: all outputs 0, FSM=StMsg, word_cnt=0, partial register empty, process_pending=0.
// - Lane writes are registered: an accepted word appears on state_* exactly 1 cycle after the handshake, addr=word_cnt.
// - msg_ready_o=1 only in StMsg with no partial word held. It is 0 in all other states.
// - Legal strobes: 8'hFF (full word) or 2^n-1 with n=1..7 (partial word).
//   - strb=0: word consumed and dropped, no error.
//   - Any other pattern: word dropped, err_o pulses.
// - Full word: written; word_cnt++.
//   - If word_cnt was BlockWords-1: go to StRun, pulse run_o the cycle after the last lane write, word_cnt->0.
// - Partial word (n bytes): held internally, not written; msg_ready_o drops until process_i.
// - StRun: wait for run_done_i, then return to StMsg.
//   - A process_i seen during StRun sets process_pending; padding then starts immediately after run_done_i.
// - process_i in StMsg -> StPad. Write lane word_cnt with data = held bytes | (PadByte << 8n), where n=0 if nothing is held.
//   - If word_cnt==BlockWords-1, also OR 64'h80<<56. For n=7 the top byte becomes 8'h86.
// - StZero: write zero lanes for word_cnt+1..BlockWords-1, one per cycle. The final lane carries bit 63 set.
//   - StZero is skipped when the pad lane was the last lane.
// - StFinal: pulse run_o, wait run_done_i, pulse absorbed_o, go to StDone.
//   - StDone holds msg_ready_o=0 and ignores process_i until clear_i.
// - Message of exactly k*BlockWords full words: after the k-th run, process_i yields a full pad block.
//   - That block is lane0 = PadByte, lanes 1..BlockWords-2 = 0, last lane = 64'h8000_0000_0000_0000.
// - clear_i has priority over every other event in every state.
//   - FSM->StMsg, word_cnt=0, partial and process_pending cleared.
//   - A pending run_done_i is ignored, and no absorbed_o is generated.
// - process_i while already in StPad/StZero/StFinal/StDone is ignored.
// - run_done_i outside StRun/StFinal is ignored.
// STRUCTURE
// - kmac_pkg additions:
//   - MsgWidth and KeccakLanes=25 constants.
//   - Function pad_lane(data, nbytes, last, padbyte) returning the padded lane.
//   - Function strb_valid(strb) returning a legal/partial/full classification.
// - FSM enum absorb_st_e {StMsg, StRun, StPad, StZero, StFinal, StDone} is local.
//   - It is encoded with prim_sparse_fsm_flop; an illegal state forces StDone with err_o.
// - No sub-module; single file, datapath and FSM only.
// TESTING
// - BlockWords=17, send 3 full words, process_i:
//   - lanes 0..2 = data, lane 3 = 64'h06, lanes 4..15 = 0, lane 16 = 64'h8000_0000_0000_0000.
//   - One run_o, then absorbed_o one cycle after run_done_i.
// - Send 17 full words, process_i asserted during StRun:
//   - first run_o, then a full pad block (lane0=06, lane16=8000..00), second run_o, absorbed_o.
// - Send 16 full words, then data 64'h00AA_BBCC_DDEE_FF11 with strb 8'h7F, then process_i:
//   - lane 16 = 64'h86AA_BBCC_DDEE_FF11, no zero lanes written.
// - strb 8'h05 -> err_o pulse, no state write, word_cnt unchanged.
//   - strb 8'h00 -> silently consumed.
// - clear_i in the cycle run_done_i rises during StFinal:
//   - no absorbed_o, msg_ready_o=1 next cycle, next write uses addr 0.
// - Reset asserted mid-StZero: all outputs 0 asynchronously; after release the first accepted word is written to lane 0.

Source files
------------

// File: rtl/kmac_msg_absorb_pkg.sv
// Shared constants and helpers for the KMAC message absorber.
//   MsgWidth    : lane / message word width (64 only)
//   KeccakLanes : lanes in the Keccak-f[1600] state
//   strb_valid  : classifies a byte strobe as zero / partial / full / illegal
//   strb_nbytes : byte count of a contiguous partial strobe
//   pad_lane    : builds a pad lane from held bytes, pad byte and last-lane flag
package kmac_msg_absorb_pkg;

  localparam int unsigned MsgWidth    = 64;
  localparam int unsigned KeccakLanes = 25;

  typedef enum logic [1:0] {
    StrbZero,
    StrbPartial,
    StrbFull,
    StrbIllegal
  } strb_cls_e;

  function automatic strb_cls_e strb_valid(input logic [7:0] strb);
    strb_cls_e cls;
    case (strb)
      8'h00:                               cls = StrbZero;
      8'hFF:                               cls = StrbFull;
      8'h01, 8'h03, 8'h07, 8'h0F,
      8'h1F, 8'h3F, 8'h7F:                 cls = StrbPartial;
      default:                             cls = StrbIllegal;
    endcase
    return cls;
  endfunction

  function automatic logic [2:0] strb_nbytes(input logic [7:0] strb);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      n = n + {2'b00, strb[i]};
    end
    return n;
  endfunction

  function automatic logic [63:0] pad_lane(input logic [63:0] data,
                                           input logic [2:0]  nbytes,
                                           input logic        last,
                                           input logic [7:0]  padbyte);
    logic [63:0] lane;
    lane = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < 32'(nbytes)) lane[8*i +: 8] = data[8*i +: 8];
    end
    lane = lane | ({56'd0, padbyte} << {nbytes, 3'b000});
    if (last) lane[63] = 1'b1;
    return lane;
  endfunction

endpackage

// File: rtl/kmac_msg_absorb.sv
// KMAC message absorber: consumer end of the MSG interface.
// Writes message words lane by lane into the Keccak state (XOR-in strobe),
// kicks a permutation after every full rate block, and on process_i appends
// the SHA3/cSHAKE pad, runs the final block and pulses absorbed_o.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   msg_valid_i/msg_data_i/msg_strb_i    message word in (little-endian bytes)
//   msg_ready_o                          word accepted when valid & ready
//   process_i, clear_i                   finish message / drop all context
//   state_valid_o/addr_o/data_o          registered lane write into the state
//   run_o, run_done_i                    permutation start pulse / done
//   absorbed_o                           final block permuted (pulse)
//   err_o                                illegal strobe or FSM state (pulse)
module kmac_msg_absorb
  import kmac_msg_absorb_pkg::*;
#(
  parameter int unsigned MsgWidth   = 64,
  parameter int unsigned BlockWords = 17,
  parameter logic [7:0]  PadByte    = 8'h06,
  parameter int unsigned AddrW      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  msg_valid_i,
  input  logic [MsgWidth-1:0]   msg_data_i,
  input  logic [MsgWidth/8-1:0] msg_strb_i,
  output logic                  msg_ready_o,
  input  logic                  process_i,
  input  logic                  clear_i,
  output logic                  state_valid_o,
  output logic [AddrW-1:0]      state_addr_o,
  output logic [MsgWidth-1:0]   state_data_o,
  output logic                  run_o,
  input  logic                  run_done_i,
  output logic                  absorbed_o,
  output logic                  err_o
);

  // Sparse encoding: every pair of states differs in at least two bits so a
  // single upset lands in the default branch.
  typedef enum logic [5:0] {
    StMsg   = 6'b001110,
    StRun   = 6'b110100,
    StPad   = 6'b011001,
    StZero  = 6'b100011,
    StFinal = 6'b101101,
    StDone  = 6'b010110
  } absorb_st_e;

  localparam logic [AddrW-1:0] LastLane = AddrW'(BlockWords - 1);

  absorb_st_e            st_q, st_d;
  logic [AddrW-1:0]      cnt_q, cnt_d;
  logic [MsgWidth-1:0]   part_q, part_d;
  logic [2:0]            partn_q, partn_d;
  logic                  partv_q, partv_d;
  logic                  pend_q, pend_d;
  logic                  kick_q, kick_d;
  logic                  sv_q, sv_d;
  logic [AddrW-1:0]      addr_q, addr_d;
  logic [MsgWidth-1:0]   data_q, data_d;
  logic                  run_q, run_d;
  logic                  abs_q, abs_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  last_lane;
  strb_cls_e             strb_cls;

  // pend_q blocks further words once a process request has been captured
  // together with an accepted word.
  assign msg_ready_o = rst_ni && (st_q == StMsg) && !partv_q && !pend_q;
  assign accept      = msg_valid_i && msg_ready_o;
  assign last_lane   = (cnt_q == LastLane);
  assign strb_cls    = strb_valid(msg_strb_i);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    partn_d = partn_q;
    partv_d = partv_q;
    pend_d  = pend_q;
    kick_d  = kick_q;
    sv_d    = 1'b0;
    addr_d  = cnt_q;
    data_d  = '0;
    run_d   = 1'b0;
    abs_d   = 1'b0;
    err_d   = 1'b0;

    if (clear_i) begin
      st_d    = StMsg;
      cnt_d   = '0;
      part_d  = '0;
      partn_d = '0;
      partv_d = 1'b0;
      pend_d  = 1'b0;
      kick_d  = 1'b0;
    end else begin
      unique case (st_q)
        StMsg: begin
          if (accept) begin
            // Word and process_i together: absorb the word first, pad after.
            if (process_i) pend_d = 1'b1;
            case (strb_cls)
              StrbFull: begin
                sv_d   = 1'b1;
                data_d = msg_data_i;
                if (last_lane) begin
                  cnt_d  = '0;
                  st_d   = StRun;
                  kick_d = 1'b1;
                end else begin
                  cnt_d = cnt_q + AddrW'(1);
                end
              end
              StrbPartial: begin
                partv_d = 1'b1;
                part_d  = msg_data_i;
                partn_d = strb_nbytes(msg_strb_i);
              end
              StrbIllegal: err_d = 1'b1;
              default: ;
            endcase
          end else if (process_i || pend_q) begin
            st_d   = StPad;
            pend_d = 1'b0;
          end
        end
        StRun: begin
          if (process_i) pend_d = 1'b1;
          if (kick_q) begin
            run_d  = 1'b1;
            kick_d = 1'b0;
          end else if (run_done_i) begin
            if (pend_q || process_i) begin
              st_d   = StPad;
              pend_d = 1'b0;
            end else begin
              st_d = StMsg;
            end
          end
        end
        StPad: begin
          sv_d    = 1'b1;
          data_d  = pad_lane(part_q, partn_q, last_lane, PadByte);
          part_d  = '0;
          partn_d = '0;
          partv_d = 1'b0;
          if (last_lane) begin
            cnt_d  = '0;
            st_d   = StFinal;
            kick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AddrW'(1);
            st_d  = StZero;
          end
        end
        StZero: begin
          sv_d = 1'b1;
          if (last_lane) begin
            data_d[MsgWidth-1] = 1'b1;
            cnt_d              = '0;
            st_d               = StFinal;
            kick_d             = 1'b1;
          end else begin
            cnt_d = cnt_q + AddrW'(1);
          end
        end
        StFinal: begin
          if (kick_q) begin
            run_d  = 1'b1;
            kick_d = 1'b0;
          end else if (run_done_i) begin
            abs_d = 1'b1;
            st_d  = StDone;
          end
        end
        StDone: ;
        default: begin
          st_d  = StDone;
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= StMsg;
      cnt_q   <= '0;
      part_q  <= '0;
      partn_q <= '0;
      partv_q <= 1'b0;
      pend_q  <= 1'b0;
      kick_q  <= 1'b0;
      sv_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      run_q   <= 1'b0;
      abs_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      partn_q <= partn_d;
      partv_q <= partv_d;
      pend_q  <= pend_d;
      kick_q  <= kick_d;
      sv_q    <= sv_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      run_q   <= run_d;
      abs_q   <= abs_d;
      err_q   <= err_d;
    end
  end

  assign state_valid_o = sv_q;
  assign state_addr_o  = addr_q;
  assign state_data_o  = data_q;
  assign run_o         = run_q;
  assign absorbed_o    = abs_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_kmac_msg_absorb.sv
// Self-checking bench for kmac_msg_absorb (BlockWords=17, PadByte=8'h06).
module tb_kmac_msg_absorb;

  localparam int unsigned BW = 17;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        msg_valid_i;
  logic [63:0] msg_data_i;
  logic [7:0]  msg_strb_i;
  logic        msg_ready_o;
  logic        process_i;
  logic        clear_i;
  logic        state_valid_o;
  logic [4:0]  state_addr_o;
  logic [63:0] state_data_o;
  logic        run_o;
  logic        run_done_i;
  logic        absorbed_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  kmac_msg_absorb #(
    .MsgWidth  (64),
    .BlockWords(17),
    .PadByte   (8'h06),
    .AddrW     (5)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .msg_valid_i  (msg_valid_i),
    .msg_data_i   (msg_data_i),
    .msg_strb_i   (msg_strb_i),
    .msg_ready_o  (msg_ready_o),
    .process_i    (process_i),
    .clear_i      (clear_i),
    .state_valid_o(state_valid_o),
    .state_addr_o (state_addr_o),
    .state_data_o (state_data_o),
    .run_o        (run_o),
    .run_done_i   (run_done_i),
    .absorbed_o   (absorbed_o),
    .err_o        (err_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [4:0]  wr_addr[$];
  logic [63:0] wr_data[$];
  logic [4:0]  exp_addr[$];
  logic [63:0] exp_data[$];
  int unsigned run_cnt = 0;
  int unsigned abs_cnt = 0;
  int unsigned err_cnt = 0;

  always @(negedge clk_i) begin
    if (state_valid_o) begin
      wr_addr.push_back(state_addr_o);
      wr_data.push_back(state_data_o);
    end
    if (run_o)      run_cnt++;
    if (absorbed_o) abs_cnt++;
    if (err_o)      err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic flush();
    wr_addr.delete();
    wr_data.delete();
    exp_addr.delete();
    exp_data.delete();
    run_cnt = 0;
    abs_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic exp_push(input int unsigned a, input logic [63:0] d);
    exp_addr.push_back(5'(a));
    exp_data.push_back(d);
  endtask

  task automatic compare_writes(input string name);
    int unsigned n;
    chk($sformatf("%s_nwrites", name), 64'(wr_addr.size()), 64'(exp_addr.size()));
    n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
    for (int unsigned i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", name, i), 64'(wr_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("%s_data%0d", name, i), wr_data[i], exp_data[i]);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] s);
    int unsigned w;
    msg_valid_i = 1'b1;
    msg_data_i  = d;
    msg_strb_i  = s;
    w = 0;
    while (!msg_ready_o && w < 50) begin
      tick();
      w++;
    end
    chk("send_ready", 64'(msg_ready_o), 64'd1);
    tick();
    msg_valid_i = 1'b0;
    msg_strb_i  = 8'h00;
  endtask

  task automatic pulse_process();
    process_i = 1'b1;
    tick();
    process_i = 1'b0;
  endtask

  task automatic clear_all();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    flush();
  endtask

  task automatic wait_run(input string name);
    int unsigned w;
    w = 0;
    while (!run_o && w < 100) begin
      tick();
      w++;
    end
    chk(name, 64'(run_o), 64'd1);
  endtask

  task automatic run_cycle(input string name);
    wait_run(name);
    run_done_i = 1'b1;
    tick();
    run_done_i = 1'b0;
  endtask

  function automatic logic [63:0] pat(input int unsigned i);
    return 64'h0123_4567_89AB_0000 | 64'(i);
  endfunction

  typedef struct {
    logic [7:0]  strb;
    logic [63:0] data;
    logic        exp_err;
    logic        exp_ready;
    logic [4:0]  exp_next;
    int unsigned exp_writes;
    logic [63:0] exp_lane1;
  } vec_t;

  localparam logic [63:0] WX = 64'hA5A5_A5A5_0000_0001;
  localparam logic [63:0] WY = 64'h5A5A_5A5A_0000_0002;
  localparam logic [63:0] WD = 64'hDEAD_BEEF_CAFE_F00D;

  initial begin
    vec_t vecs[6];
    int unsigned w;

    rst_ni      = 1'b0;
    msg_valid_i = 1'b0;
    msg_data_i  = '0;
    msg_strb_i  = '0;
    process_i   = 1'b0;
    clear_i     = 1'b0;
    run_done_i  = 1'b0;

    // Reset state
    tick();
    chk("rst_state_valid", 64'(state_valid_o), 64'd0);
    chk("rst_run", 64'(run_o), 64'd0);
    chk("rst_absorbed", 64'(absorbed_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_ready", 64'(msg_ready_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_ready", 64'(msg_ready_o), 64'd1);

    // 3 full words then process: pad lane 3, zero lanes, last lane bit 63
    flush();
    for (int unsigned i = 0; i < 3; i++) begin
      send(pat(i), 8'hFF);
      exp_push(i, pat(i));
    end
    exp_push(3, 64'h06);
    for (int unsigned i = 4; i < BW - 1; i++) exp_push(i, 64'h0);
    exp_push(BW - 1, 64'h8000_0000_0000_0000);
    pulse_process();
    run_cycle("s1_run");
    chk("s1_absorbed", 64'(absorbed_o), 64'd1);
    tick();
    chk("s1_absorbed_pulse", 64'(absorbed_o), 64'd0);
    chk("s1_done_ready", 64'(msg_ready_o), 64'd0);
    pulse_process();
    repeat (5) tick();
    compare_writes("s1");
    chk("s1_run_cnt", 64'(run_cnt), 64'd1);
    chk("s1_abs_cnt", 64'(abs_cnt), 64'd1);

    // 17 full words, process during StRun: full pad block, two runs
    clear_all();
    for (int unsigned i = 0; i < BW; i++) begin
      send(pat(i + 32), 8'hFF);
      exp_push(i, pat(i + 32));
    end
    chk("s2_ready_in_run", 64'(msg_ready_o), 64'd0);
    pulse_process();
    exp_push(0, 64'h06);
    for (int unsigned i = 1; i < BW - 1; i++) exp_push(i, 64'h0);
    exp_push(BW - 1, 64'h8000_0000_0000_0000);
    run_cycle("s2_run1");
    run_cycle("s2_run2");
    chk("s2_absorbed", 64'(absorbed_o), 64'd1);
    tick();
    compare_writes("s2");
    chk("s2_run_cnt", 64'(run_cnt), 64'd2);

    // 16 full words plus 7-byte partial in the last lane: 8'h86 top byte
    clear_all();
    for (int unsigned i = 0; i < BW - 1; i++) begin
      send(pat(i + 64), 8'hFF);
      exp_push(i, pat(i + 64));
    end
    send(64'h00AA_BBCC_DDEE_FF11, 8'h7F);
    chk("s3_ready_partial", 64'(msg_ready_o), 64'd0);
    exp_push(BW - 1, 64'h86AA_BBCC_DDEE_FF11);
    pulse_process();
    run_cycle("s3_run");
    chk("s3_absorbed", 64'(absorbed_o), 64'd1);
    tick();
    compare_writes("s3");

    // Strobe classification table: word X, test word, then word Y if ready
    vecs[0] = '{8'hFF, WD, 1'b0, 1'b1, 5'd2, 3, WD};
    vecs[1] = '{8'h05, WD, 1'b1, 1'b1, 5'd1, 2, WY};
    vecs[2] = '{8'h00, WD, 1'b0, 1'b1, 5'd1, 2, WY};
    vecs[3] = '{8'h7F, WD, 1'b0, 1'b0, 5'd0, 1, 64'h0};
    vecs[4] = '{8'h80, WD, 1'b1, 1'b1, 5'd1, 2, WY};
    vecs[5] = '{8'h01, WD, 1'b0, 1'b0, 5'd0, 1, 64'h0};
    for (int unsigned v = 0; v < 6; v++) begin
      clear_all();
      send(WX, 8'hFF);
      send(vecs[v].data, vecs[v].strb);
      tick();
      chk($sformatf("tbl%0d_err", v), 64'(err_cnt), 64'(vecs[v].exp_err));
      chk($sformatf("tbl%0d_ready", v), 64'(msg_ready_o), 64'(vecs[v].exp_ready));
      if (vecs[v].exp_ready) begin
        send(WY, 8'hFF);
        chk($sformatf("tbl%0d_next_addr", v), 64'(wr_addr[wr_addr.size() - 1]),
            64'(vecs[v].exp_next));
      end
      tick();
      chk($sformatf("tbl%0d_nwrites", v), 64'(wr_addr.size()), 64'(vecs[v].exp_writes));
      if (vecs[v].exp_writes >= 2)
        chk($sformatf("tbl%0d_lane1", v), wr_data[1], vecs[v].exp_lane1);
    end

    // clear_i coincident with run_done_i in StFinal
    clear_all();
    send(pat(1), 8'hFF);
    send(pat(2), 8'hFF);
    pulse_process();
    wait_run("s5_run");
    run_done_i = 1'b1;
    clear_i    = 1'b1;
    tick();
    run_done_i = 1'b0;
    clear_i    = 1'b0;
    chk("s5_no_absorbed", 64'(absorbed_o), 64'd0);
    chk("s5_ready", 64'(msg_ready_o), 64'd1);
    flush();
    send(WY, 8'hFF);
    chk("s5_nwrites", 64'(wr_addr.size()), 64'd1);
    chk("s5_addr", 64'(wr_addr[0]), 64'd0);
    repeat (4) tick();
    chk("s5_abs_cnt", 64'(abs_cnt), 64'd0);

    // Asynchronous reset in the middle of StZero
    clear_all();
    for (int unsigned i = 0; i < 3; i++) send(pat(i), 8'hFF);
    pulse_process();
    w = 0;
    while (!(state_valid_o && state_addr_o == 5'd6) && w < 100) begin
      tick();
      w++;
    end
    chk("s6_in_zero", 64'(state_valid_o && state_addr_o == 5'd6), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("s6_rst_valid", 64'(state_valid_o), 64'd0);
    chk("s6_rst_addr", 64'(state_addr_o), 64'd0);
    chk("s6_rst_data", state_data_o, 64'd0);
    chk("s6_rst_run", 64'(run_o), 64'd0);
    chk("s6_rst_absorbed", 64'(absorbed_o), 64'd0);
    chk("s6_rst_err", 64'(err_o), 64'd0);
    chk("s6_rst_ready", 64'(msg_ready_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    flush();
    send(WD, 8'hFF);
    chk("s6_nwrites", 64'(wr_addr.size()), 64'd1);
    chk("s6_addr", 64'(wr_addr[0]), 64'd0);
    chk("s6_data", wr_data[0], WD);
    repeat (3) tick();
    chk("s6_run_cnt", 64'(run_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
